// File: rtl/arith_result_checker.sv
// Result checker for the arithmetic encoder: queued expected range/low pairs
// are compared against DUT outputs a fixed latency after each stimulus.
module arith_result_checker #(
  parameter int RANGE_WIDTH = 16,
  parameter int LOW_WIDTH   = 24,
  parameter int DEPTH       = 16,
  parameter int LATENCY     = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   general_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   finish,
  input  logic                   stim_valid,
  input  logic                   exp_valid,
  input  logic [RANGE_WIDTH-1:0] exp_range,
  input  logic [LOW_WIDTH-1:0]   exp_low,
  output logic                   exp_ready,
  input  logic [RANGE_WIDTH-1:0] dut_range,
  input  logic [LOW_WIDTH-1:0]   dut_low,
  output logic [CNT_WIDTH-1:0]   checked_cnt,
  output logic [CNT_WIDTH-1:0]   range_err_cnt,
  output logic [CNT_WIDTH-1:0]   low_err_cnt,
  output logic [CNT_WIDTH-1:0]   first_err_idx,
  output logic                   underflow,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done,
  output logic                   pass
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t state;

  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            occ;
  logic [RANGE_WIDTH-1:0] mem_range [DEPTH];
  logic [LOW_WIDTH-1:0]   mem_low   [DEPTH];
  logic [LATENCY-1:0]     tok;
  logic [LATENCY-1:0]     tok_nxt;

  logic active;
  logic full;
  logic empty;
  logic due;
  logic pop;
  logic push;
  logic drop;
  logic stim_in;
  logic range_bad;
  logic low_bad;
  logic err_seen;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign occ       = wr_ptr - rd_ptr;
  assign full      = occ == (AW+1)'(DEPTH);
  assign empty     = occ == '0;
  assign exp_ready = !full;

  assign active  = state == RUN || state == DRAIN;
  assign stim_in = state == RUN && stim_valid;
  assign due     = tok[LATENCY-1];
  assign pop     = due && !empty;
  // A full FIFO still takes a push when the head leaves this cycle
  assign push    = active && exp_valid && (!full || pop);
  assign drop    = active && exp_valid && full && !pop;

  assign range_bad = pop && (dut_range != mem_range[rd_ptr[AW-1:0]]);
  assign low_bad   = pop && (dut_low != mem_low[rd_ptr[AW-1:0]]);
  assign err_seen  = range_err_cnt != '0 || low_err_cnt != '0;

  always_comb begin
    tok_nxt    = tok << 1;
    tok_nxt[0] = stim_in;
  end

  always_ff @(posedge general_clk) begin
    if (push) begin
      mem_range[wr_ptr[AW-1:0]] <= exp_range;
      mem_low[wr_ptr[AW-1:0]]   <= exp_low;
    end
  end

  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tok           <= '0;
      checked_cnt   <= '0;
      range_err_cnt <= '0;
      low_err_cnt   <= '0;
      first_err_idx <= '1;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else if (start) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tok           <= '0;
      checked_cnt   <= '0;
      range_err_cnt <= '0;
      low_err_cnt   <= '0;
      first_err_idx <= '1;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      tok <= tok_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + (AW+1)'(1);
        checked_cnt <= sat_inc(checked_cnt);
        if (range_bad) range_err_cnt <= sat_inc(range_err_cnt);
        if (low_bad) low_err_cnt <= sat_inc(low_err_cnt);
        if ((range_bad || low_bad) && !err_seen) first_err_idx <= checked_cnt;
      end else if (due) begin
        underflow <= 1'b1;
      end
      if (drop) overflow <= 1'b1;
      unique case (state)
        RUN:     if (finish) state <= (tok_nxt == '0) ? FIN : DRAIN;
        DRAIN:   if (tok_nxt == '0) state <= FIN;
        default: ;
      endcase
    end
  end

  assign busy = active;
  assign done = state == FIN;
  assign pass = done && range_err_cnt == '0 && low_err_cnt == '0 &&
                !underflow && !overflow && empty;

endmodule

// File: tb/tb_arith_result_checker.sv
// Bench for arith_result_checker: randomized runs against a queue-based model
// (LATENCY=2, DEPTH=4) plus directed runs on a LATENCY=5, 8-bit-counter copy.
module tb_arith_result_checker;

  localparam int LAT = 2;
  localparam int DEP = 4;
  localparam int LATB = 5;
  localparam int DEPB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_start, a_finish, a_stim, a_ev, a_ready;
  logic [15:0] a_er, a_dr;
  logic [23:0] a_el, a_dl;
  logic [15:0] a_chk, a_rerr, a_lerr, a_first;
  logic a_uf, a_of, a_busy, a_done, a_pass;

  logic b_start, b_finish, b_stim, b_ev, b_ready;
  logic [15:0] b_er, b_dr;
  logic [23:0] b_el, b_dl;
  logic [7:0] b_chk, b_rerr, b_lerr, b_first;
  logic b_uf, b_of, b_busy, b_done, b_pass;

  arith_result_checker #(
    .RANGE_WIDTH(16), .LOW_WIDTH(24), .DEPTH(DEP), .LATENCY(LAT), .CNT_WIDTH(16)
  ) u_a (
    .general_clk(clk), .reset(rst_n), .start(a_start), .finish(a_finish),
    .stim_valid(a_stim), .exp_valid(a_ev), .exp_range(a_er), .exp_low(a_el),
    .exp_ready(a_ready), .dut_range(a_dr), .dut_low(a_dl),
    .checked_cnt(a_chk), .range_err_cnt(a_rerr), .low_err_cnt(a_lerr),
    .first_err_idx(a_first), .underflow(a_uf), .overflow(a_of),
    .busy(a_busy), .done(a_done), .pass(a_pass)
  );

  arith_result_checker #(
    .RANGE_WIDTH(16), .LOW_WIDTH(24), .DEPTH(DEPB), .LATENCY(LATB), .CNT_WIDTH(8)
  ) u_b (
    .general_clk(clk), .reset(rst_n), .start(b_start), .finish(b_finish),
    .stim_valid(b_stim), .exp_valid(b_ev), .exp_range(b_er), .exp_low(b_el),
    .exp_ready(b_ready), .dut_range(b_dr), .dut_low(b_dl),
    .checked_cnt(b_chk), .range_err_cnt(b_rerr), .low_err_cnt(b_lerr),
    .first_err_idx(b_first), .underflow(b_uf), .overflow(b_of),
    .busy(b_busy), .done(b_done), .pass(b_pass)
  );

  logic [69:0] a_vec;
  assign a_vec = {a_chk, a_rerr, a_lerr, a_first,
                  a_uf, a_of, a_busy, a_done, a_pass, a_ready};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of expected pairs, queue of stimulus timestamps
  logic [39:0] m_q[$];
  int m_ts[$];
  int cyc = 0;
  int m_phase = 0;  // 0 idle, 1 run, 2 drain, 3 done
  int m_chk, m_rerr, m_lerr, m_first;
  bit m_uf, m_of;

  function automatic int sat(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_ts.delete();
    m_chk = 0;
    m_rerr = 0;
    m_lerr = 0;
    m_first = 65535;
    m_uf = 0;
    m_of = 0;
  endtask

  function automatic logic [69:0] m_vec();
    logic dn;
    logic ok;
    dn = m_phase == 3;
    ok = dn && m_rerr == 0 && m_lerr == 0 && !m_uf && !m_of && m_q.size() == 0;
    return {16'(m_chk), 16'(m_rerr), 16'(m_lerr), 16'(m_first),
            m_uf, m_of, (m_phase == 1 || m_phase == 2), dn, ok,
            (m_q.size() < DEP)};
  endfunction

  task automatic cyc_a(input bit st, input bit fin, input bit sv, input bit ev,
                       input logic [15:0] er, input logic [23:0] el,
                       input logic [15:0] dr, input logic [23:0] dl);
    logic [39:0] h;
    bit rb, lb;
    @(negedge clk);
    a_start = st; a_finish = fin; a_stim = sv; a_ev = ev;
    a_er = er; a_el = el; a_dr = dr; a_dl = dl;
    @(posedge clk);
    cyc++;
    if (st) begin
      m_clear();
      m_phase = 1;
    end else begin
      if (m_ts.size() > 0 && m_ts[0] + LAT == cyc) begin
        void'(m_ts.pop_front());
        if (m_q.size() > 0) begin
          h = m_q.pop_front();
          rb = h[39:24] != dr;
          lb = h[23:0] != dl;
          if ((rb || lb) && m_rerr == 0 && m_lerr == 0) m_first = m_chk;
          if (rb) m_rerr = sat(m_rerr);
          if (lb) m_lerr = sat(m_lerr);
          m_chk = sat(m_chk);
        end else begin
          m_uf = 1;
        end
      end
      if (ev && (m_phase == 1 || m_phase == 2)) begin
        if (m_q.size() < DEP) m_q.push_back({er, el});
        else m_of = 1;
      end
      if (sv && m_phase == 1) m_ts.push_back(cyc);
      if (m_phase == 1 && fin) m_phase = 2;
      if (m_phase == 2 && m_ts.size() == 0) m_phase = 3;
    end
    #1;
    a_start = 0; a_finish = 0; a_stim = 0; a_ev = 0;
  endtask

  task automatic cyc_b(input bit st, input bit fin, input bit sv, input bit ev,
                       input logic [15:0] er, input logic [23:0] el,
                       input logic [15:0] dr, input logic [23:0] dl);
    @(negedge clk);
    b_start = st; b_finish = fin; b_stim = sv; b_ev = ev;
    b_er = er; b_el = el; b_dr = dr; b_dl = dl;
    @(posedge clk);
    #1;
    b_start = 0; b_finish = 0; b_stim = 0; b_ev = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    m_clear();
    m_phase = 0;
    vectors++;
    if (a_vec !== m_vec()) begin
      miscompares++;
      $display("FAIL reset_a got %h want %h", a_vec, m_vec());
    end
    vectors++;
    if ({b_chk, b_rerr, b_lerr, b_first, b_uf, b_of, b_busy, b_done, b_pass,
         b_ready} !== {8'h00, 8'h00, 8'h00, 8'hFF, 6'b000001}) begin
      miscompares++;
      $display("FAIL reset_b got %h/%h/%h/%h flags %b", b_chk, b_rerr, b_lerr,
               b_first, {b_uf, b_of, b_busy, b_done, b_pass, b_ready});
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_run(input bit corrupt);
    logic [15:0] r[10];
    logic [23:0] l[10];
    logic [15:0] dr;
    logic [23:0] dl;
    for (int i = 0; i < 10; i++) begin
      r[i] = 16'($urandom);
      l[i] = 24'($urandom);
    end
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    for (int k = 0; k < 12; k++) begin
      dr = 16'($urandom);
      dl = 24'($urandom);
      if (k >= 2) begin
        dr = r[k-2];
        dl = l[k-2];
        if (corrupt && k == 5) dr = dr ^ 16'($urandom_range(1, 65535));
      end
      if (k < 10) cyc_a(1'b0, k == 9, 1, 1, r[k], l[k], dr, dl);
      else cyc_a(0, 0, 0, 0, '0, '0, dr, dl);
      vectors++;
      if (a_vec !== m_vec()) begin
        miscompares++;
        $display("FAIL run_cycle%0d got %h want %h", k, a_vec, m_vec());
      end
    end
    vectors++;
    if (a_chk !== 16'd10 || a_rerr !== (corrupt ? 16'd1 : 16'd0) ||
        a_lerr !== 16'd0 || a_first !== (corrupt ? 16'd3 : 16'hFFFF)) begin
      miscompares++;
      $display("FAIL run_counts got %0d/%0d/%0d/%h want 10/%0d/0/%h", a_chk,
               a_rerr, a_lerr, a_first, corrupt, corrupt ? 16'd3 : 16'hFFFF);
    end
    vectors++;
    if (a_done !== 1'b1 || a_pass !== !corrupt) begin
      miscompares++;
      $display("FAIL run_verdict got done=%b pass=%b want done=1 pass=%b",
               a_done, a_pass, !corrupt);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r0;
    logic [23:0] l0;
    r0 = 16'($urandom);
    l0 = 24'($urandom);
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 1, r0, l0, '0, '0);
    for (int k = 1; k < 4; k++) begin
      vectors++;
      if (a_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_ready_early got %b want 1", a_ready);
      end
      cyc_a(0, 0, 0, 1, 16'($urandom), 24'($urandom), '0, '0);
    end
    vectors++;
    if (a_ready !== 1'b0 || a_of !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_full got ready=%b of=%b want 0/0", a_ready, a_of);
    end
    cyc_a(0, 0, 1, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 1, 16'($urandom), 24'($urandom), r0, l0);
    vectors++;
    if (a_vec !== m_vec() || a_of !== 1'b0 || a_ready !== 1'b0 ||
        a_chk !== 16'd1) begin
      miscompares++;
      $display("FAIL ovf_concurrent got %h want %h", a_vec, m_vec());
    end
    cyc_a(0, 0, 0, 1, 16'($urandom), 24'($urandom), '0, '0);
    vectors++;
    if (a_of !== 1'b1 || a_vec !== m_vec()) begin
      miscompares++;
      $display("FAIL ovf_drop got %h want %h", a_vec, m_vec());
    end
    cyc_a(0, 1, 0, 0, '0, '0, '0, '0);
    vectors++;
    if (a_done !== 1'b1 || a_pass !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_verdict got done=%b pass=%b want 1/0", a_done, a_pass);
    end
  endtask

  task automatic test_underflow();
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 1, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 0, '0, '0, '0, '0);
    vectors++;
    if (a_uf !== 1'b0) begin
      miscompares++;
      $display("FAIL udf_early got %b want 0", a_uf);
    end
    cyc_a(0, 0, 0, 0, '0, '0, '0, '0);
    vectors++;
    if (a_uf !== 1'b1 || a_chk !== 16'd0 || a_vec !== m_vec()) begin
      miscompares++;
      $display("FAIL udf_flag got %h want %h", a_vec, m_vec());
    end
    cyc_a(0, 1, 0, 0, '0, '0, '0, '0);
    vectors++;
    if (a_done !== 1'b1 || a_pass !== 1'b0) begin
      miscompares++;
      $display("FAIL udf_verdict got done=%b pass=%b want 1/0", a_done, a_pass);
    end
  endtask

  task automatic test_random();
    logic [39:0] h;
    int sel;
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    for (int k = 0; k < 200; k++) begin
      h = {16'($urandom), 24'($urandom)};
      sel = $urandom_range(0, 5);
      if (m_q.size() > 0 && sel != 0) begin
        h = m_q[0];
        if (sel == 1) h[24] = ~h[24];
        if (sel == 2) h[0] = ~h[0];
      end
      cyc_a(1'b0, k == 199, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
            16'($urandom), 24'($urandom), h[39:24], h[23:0]);
      vectors++;
      if (a_vec !== m_vec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d got %h want %h", k, a_vec, m_vec());
      end
    end
    for (int i = 0; i < LAT + 2 && m_phase != 3; i++) begin
      cyc_a(0, 0, 0, 0, '0, '0, 16'($urandom), 24'($urandom));
      vectors++;
      if (a_vec !== m_vec()) begin
        miscompares++;
        $display("FAIL random_drain got %h want %h", a_vec, m_vec());
      end
    end
    vectors++;
    if (a_done !== 1'b1) begin
      miscompares++;
      $display("FAIL random_done got %b want 1", a_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r0;
    logic [23:0] l0;
    r0 = 16'($urandom);
    l0 = 24'($urandom);
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 1, 1, 16'($urandom), 24'($urandom), '0, '0);
    cyc_a(0, 0, 1, 1, 16'($urandom), 24'($urandom), '0, '0);
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 0, '0, '0, '0, '0);
    vectors++;
    if (a_vec !== m_vec() || a_chk !== 16'd0 || a_uf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart got %h want %h", a_vec, m_vec());
    end
    cyc_a(1, 1, 0, 0, '0, '0, '0, '0);
    vectors++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_start_wins got busy=%b done=%b want 1/0", a_busy, a_done);
    end
    cyc_a(0, 1, 1, 1, r0, l0, '0, '0);
    cyc_a(0, 0, 0, 0, '0, '0, '0, '0);
    cyc_a(0, 0, 0, 0, '0, '0, r0, l0);
    vectors++;
    if (a_vec !== m_vec() || a_pass !== 1'b1 || a_chk !== 16'd1) begin
      miscompares++;
      $display("FAIL b2b_finish got %h want %h", a_vec, m_vec());
    end
  endtask

  task automatic test_reset_midrun();
    cyc_a(1, 0, 0, 0, '0, '0, '0, '0);
    for (int k = 0; k < 6; k++)
      cyc_a(0, 0, 1, 1, 16'h0000, 24'h0, 16'hFFFF, 24'h1);
    vectors++;
    if (a_rerr !== 16'd4 || a_lerr !== 16'd4 || a_first !== 16'd0) begin
      miscompares++;
      $display("FAIL midrun_counts got %0d/%0d/%h want 4/4/0000", a_rerr,
               a_lerr, a_first);
    end
    #2;
    rst_n = 0;
    #1;
    m_clear();
    m_phase = 0;
    vectors++;
    if (a_vec !== {16'h0, 16'h0, 16'h0, 16'hFFFF, 6'b000001}) begin
      miscompares++;
      $display("FAIL midrun_reset got %h want %h", a_vec,
               {16'h0, 16'h0, 16'h0, 16'hFFFF, 6'b000001});
    end
    @(negedge clk);
    rst_n = 1;
    test_run(0);
  endtask

  task automatic test_leftover();
    logic [15:0] r0;
    logic [23:0] l0;
    r0 = 16'($urandom);
    l0 = 24'($urandom);
    cyc_b(1, 0, 0, 0, '0, '0, r0, l0);
    cyc_b(0, 0, 1, 1, r0, l0, r0, l0);
    cyc_b(0, 0, 1, 1, r0, l0, r0, l0);
    cyc_b(0, 1, 0, 1, r0, l0, r0, l0);
    for (int i = 0; i < 20 && !b_done; i++) cyc_b(0, 0, 0, 0, '0, '0, r0, l0);
    vectors++;
    if (b_done !== 1'b1 || b_pass !== 1'b0 || b_chk !== 8'd2 ||
        b_rerr !== 8'd0 || b_lerr !== 8'd0 || b_uf !== 1'b0 || b_of !== 1'b0) begin
      miscompares++;
      $display("FAIL leftover got done=%b pass=%b chk=%0d err=%0d/%0d uf=%b of=%b",
               b_done, b_pass, b_chk, b_rerr, b_lerr, b_uf, b_of);
    end
  endtask

  task automatic test_saturate();
    cyc_b(1, 0, 0, 0, '0, '0, 16'h1, 24'h0);
    for (int k = 0; k < 300; k++) begin
      cyc_b(0, 0, 1, 1, 16'h0, 24'h0, 16'h1, 24'h0);
      if (k == 199) begin
        vectors++;
        if (b_rerr !== 8'd195 || b_chk !== 8'd195) begin
          miscompares++;
          $display("FAIL sat_mid got %0d/%0d want 195/195", b_rerr, b_chk);
        end
      end
    end
    cyc_b(0, 1, 0, 0, '0, '0, 16'h1, 24'h0);
    for (int i = 0; i < 20 && !b_done; i++) cyc_b(0, 0, 0, 0, '0, '0, 16'h1, 24'h0);
    vectors++;
    if (b_rerr !== 8'hFF || b_chk !== 8'hFF || b_lerr !== 8'd0 ||
        b_first !== 8'd0 || b_done !== 1'b1 || b_pass !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate got rerr=%h chk=%h lerr=%h first=%h done=%b pass=%b",
               b_rerr, b_chk, b_lerr, b_first, b_done, b_pass);
    end
  endtask

  initial begin
    a_start = 0; a_finish = 0; a_stim = 0; a_ev = 0;
    a_er = '0; a_el = '0; a_dr = '0; a_dl = '0;
    b_start = 0; b_finish = 0; b_stim = 0; b_ev = 0;
    b_er = '0; b_el = '0; b_dr = '0; b_dl = '0;
    test_reset();
    test_run(0);
    test_run(1);
    test_overflow();
    test_underflow();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_leftover();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
